// File: rtl/mem_responder.sv
// Data-memory responder: serves one core load/store at a time after WAIT_STATES wait cycles, with a host port and access counters.
// Latency: ack rises WAIT_STATES+1 cycles after request capture; host reads return data 1 cycle after the strobe.
// Backpressure: a single transaction is in flight, ack is held until req drops, and the host port is served only while idle.
module mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        init_n,
    input  logic        req,
    input  logic        we,
    input  logic [7:0]  addr,
    input  logic [7:0]  wdata,
    output logic        ack,
    output logic [7:0]  rdata,
    output logic        err,
    output logic        busy,
    input  logic        host_en,
    input  logic        host_we,
    input  logic [7:0]  host_addr,
    input  logic [7:0]  host_wdata,
    output logic [7:0]  host_rdata,
    input  logic        cnt_clr,
    output logic [15:0] rd_cnt,
    output logic [15:0] wr_cnt
);
    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0] DEPTH_W = 9'(DEPTH);
    localparam logic [2:0] WS_W    = 3'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_ACK} state_t;
    state_t state_q, state_d;

    // Latched request and working registers
    logic          we_q;
    logic [7:0]    addr_q;
    logic [7:0]    wdata_q;
    logic [2:0]    wcnt_q;
    logic [7:0]    rdata_q;
    logic          err_q;
    logic [7:0]    host_rdata_q;
    logic [15:0]   rd_cnt_q;
    logic [15:0]   wr_cnt_q;

    // Storage is deliberately left without reset
    logic [7:0]    mem [DEPTH];

    logic          capture;
    logic          host_go;
    logic          do_access;
    logic          core_in_range;
    logic          host_in_range;
    logic          mem_we;
    logic [AW-1:0] core_idx;
    logic [AW-1:0] host_idx;
    logic [AW-1:0] wr_idx;
    logic [7:0]    wr_dat;

    // Host strobe wins over a pending core request; req simply stays pending
    assign capture       = (state_q == S_IDLE) && req && !host_en;
    assign host_go       = (state_q == S_IDLE) && host_en;
    assign do_access     = (state_q == S_ACCESS);
    assign core_in_range = {1'b0, addr_q} < DEPTH_W;
    assign host_in_range = {1'b0, host_addr} < DEPTH_W;
    assign core_idx      = addr_q[AW-1:0];
    assign host_idx      = host_addr[AW-1:0];

    // Core and host never write in the same cycle: host only in IDLE, core only in ACCESS
    assign mem_we = (do_access && we_q && core_in_range) ||
                    (host_go && host_we && host_in_range);
    assign wr_idx = do_access ? core_idx : host_idx;
    assign wr_dat = do_access ? wdata_q : host_wdata;

    // State register
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a req drop during WAIT does not abort the transaction
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (capture) state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
            S_WAIT:   if (wcnt_q == 3'd1) state_d = S_ACCESS;
            S_ACCESS: state_d = S_ACK;
            S_ACK:    if (!req) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        ack  = (state_q == S_ACK);
        busy = (state_q != S_IDLE);
    end

    // Memory write port shared by core stores and host writes
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_idx] <= wr_dat;
        end
    end

    // Request latch, wait countdown, load data, error flag and host read data
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            we_q         <= 1'b0;
            addr_q       <= 8'h00;
            wdata_q      <= 8'h00;
            wcnt_q       <= 3'd0;
            rdata_q      <= 8'h00;
            err_q        <= 1'b0;
            host_rdata_q <= 8'h00;
        end else begin
            if (capture) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
                wcnt_q  <= WS_W;
            end else if (state_q == S_WAIT) begin
                wcnt_q <= wcnt_q - 3'd1;
            end

            if (do_access) begin
                if (!core_in_range) begin
                    rdata_q <= 8'h00;
                end else if (!we_q) begin
                    rdata_q <= mem[core_idx];
                end
                err_q <= !core_in_range;
            end else if (state_q == S_ACK && !req) begin
                err_q <= 1'b0;
            end

            if (host_go && !host_we) begin
                host_rdata_q <= host_in_range ? mem[host_idx] : 8'h00;
            end
        end
    end

    // Saturating access counters; clear beats a same-cycle increment
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            rd_cnt_q <= 16'h0000;
            wr_cnt_q <= 16'h0000;
        end else if (cnt_clr) begin
            rd_cnt_q <= 16'h0000;
            wr_cnt_q <= 16'h0000;
        end else if (do_access) begin
            if (we_q) begin
                if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
            end else begin
                if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
            end
        end
    end

    assign rdata      = rdata_q;
    assign err        = err_q;
    assign host_rdata = host_rdata_q;
    assign rd_cnt     = rd_cnt_q;
    assign wr_cnt     = wr_cnt_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder with DEPTH=128, WAIT_STATES=1.
// Core transactions push expected results to a scoreboard that is popped when ack rises.
// Host port, counter saturation/clear and mid-transaction reset are covered as well.
module tb_mem_responder;
    logic        clk        = 1'b0;
    logic        init_n     = 1'b1;
    logic        req        = 1'b0;
    logic        we         = 1'b0;
    logic [7:0]  addr       = 8'h00;
    logic [7:0]  wdata      = 8'h00;
    logic        ack;
    logic [7:0]  rdata;
    logic        err;
    logic        busy;
    logic        host_en    = 1'b0;
    logic        host_we    = 1'b0;
    logic [7:0]  host_addr  = 8'h00;
    logic [7:0]  host_wdata = 8'h00;
    logic [7:0]  host_rdata;
    logic        cnt_clr    = 1'b0;
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;

    mem_responder #(.DEPTH(128), .WAIT_STATES(1)) dut (
        .clk        (clk),
        .init_n     (init_n),
        .req        (req),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .ack        (ack),
        .rdata      (rdata),
        .err        (err),
        .busy       (busy),
        .host_en    (host_en),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .cnt_clr    (cnt_clr),
        .rd_cnt     (rd_cnt),
        .wr_cnt     (wr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] rd;
        logic       err;
        logic       ld;
    } exp_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [15:0] m_rd   = 16'h0000;
    logic [15:0] m_wr   = 16'h0000;

    task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_wr(input logic [7:0] a, input logic [7:0] d);
        host_en = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
        tick();
        host_en = 1'b0; host_we = 1'b0;
    endtask

    task automatic host_rd(input string tag, input logic [7:0] a, input logic [7:0] e);
        host_en = 1'b1; host_we = 1'b0; host_addr = a;
        tick();
        check_val(tag, 16'(host_rdata), 16'(e));
        host_en = 1'b0;
    endtask

    // One full 4-phase core transaction; optionally collides with a host read in the first cycle
    task automatic core_txn(input logic w, input logic [7:0] a, input logic [7:0] d,
                            input logic [7:0] e_rd, input logic e_err, input int e_lat,
                            input logic hc, input logic [7:0] ha, input logic [7:0] h_exp);
        exp_t e;
        int   n;
        int   cap;
        sb.push_back('{rd: e_rd, err: e_err, ld: !w});
        req = 1'b1; we = w; addr = a; wdata = d;
        if (hc) begin
            host_en = 1'b1; host_we = 1'b0; host_addr = ha;
        end
        cap = hc ? 2 : 1;
        n = 0;
        do begin
            tick();
            n++;
            if (hc && n == 1) begin
                check_val("host_prio_rdata", 16'(host_rdata), 16'(h_exp));
                check_val("host_prio_busy", 16'(busy), 16'h0);
                host_en = 1'b0;
            end
            if (n == cap) begin
                check_val("busy_rise", 16'(busy), 16'h1);
                // Request inputs must be ignored once latched
                we = !w; addr = ~a; wdata = ~d;
            end
        end while (!ack && n < 20);
        check_val("ack_seen", 16'(ack), 16'h1);
        check_val("ack_latency", 16'(n), 16'(e_lat));
        if (cnt_clr) begin
            m_rd = 16'h0000; m_wr = 16'h0000;
        end else if (w) begin
            m_wr = sat_inc(m_wr);
        end else begin
            m_rd = sat_inc(m_rd);
        end
        e = sb.pop_front();
        if (e.ld) check_val("rdata", 16'(rdata), 16'(e.rd));
        check_val("err", 16'(err), 16'(e.err));
        check_val("rd_cnt", rd_cnt, m_rd);
        check_val("wr_cnt", wr_cnt, m_wr);
        tick();
        check_val("ack_hold", 16'(ack), 16'h1);
        req = 1'b0;
        tick();
        check_val("ack_fall", 16'(ack), 16'h0);
        check_val("busy_fall", 16'(busy), 16'h0);
        check_val("err_fall", 16'(err), 16'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Asynchronous reset, checked before any clock edge
        #2 init_n = 1'b0;
        #1;
        check_val("rst_ack", 16'(ack), 16'h0);
        check_val("rst_busy", 16'(busy), 16'h0);
        check_val("rst_rdata", 16'(rdata), 16'h0);
        check_val("rst_err", 16'(err), 16'h0);
        check_val("rst_host_rdata", 16'(host_rdata), 16'h0);
        check_val("rst_rd_cnt", rd_cnt, 16'h0);
        check_val("rst_wr_cnt", wr_cnt, 16'h0);
        @(negedge clk);
        init_n = 1'b1;
        tick();

        // Host preload then core load
        host_wr(8'h10, 8'hA5);
        core_txn(1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 3, 1'b0, 8'h00, 8'h00);

        // Core store, read back through host port
        core_txn(1'b1, 8'h20, 8'h3C, 8'h00, 1'b0, 3, 1'b0, 8'h00, 8'h00);
        host_rd("host_rd_store", 8'h20, 8'h3C);

        // Out-of-range load and store
        host_wr(8'h00, 8'h11);
        core_txn(1'b0, 8'h80, 8'h00, 8'h00, 1'b1, 3, 1'b0, 8'h00, 8'h00);
        core_txn(1'b1, 8'h80, 8'h99, 8'h00, 1'b1, 3, 1'b0, 8'h00, 8'h00);
        host_rd("oor_no_alias", 8'h00, 8'h11);
        host_rd("host_rd_oor", 8'h80, 8'h00);

        // Host read and core load in the same IDLE cycle: host first, ack one cycle later
        core_txn(1'b0, 8'h20, 8'h00, 8'h3C, 1'b0, 4, 1'b1, 8'h10, 8'hA5);

        // Reset during WAIT of a store: everything clears at once, store is dropped
        host_wr(8'h05, 8'h42);
        req = 1'b1; we = 1'b1; addr = 8'h05; wdata = 8'h77;
        tick();
        check_val("mid_busy", 16'(busy), 16'h1);
        #2 init_n = 1'b0;
        #1;
        check_val("mid_rst_ack", 16'(ack), 16'h0);
        check_val("mid_rst_busy", 16'(busy), 16'h0);
        check_val("mid_rst_rdata", 16'(rdata), 16'h0);
        check_val("mid_rst_rd_cnt", rd_cnt, 16'h0);
        check_val("mid_rst_wr_cnt", wr_cnt, 16'h0);
        req = 1'b0; we = 1'b0;
        #1 init_n = 1'b1;
        m_rd = 16'h0000; m_wr = 16'h0000;
        tick();
        host_rd("store_dropped", 8'h05, 8'h42);

        // Saturation: preload rd_cnt near the top, then two more loads
        force dut.rd_cnt_q = 16'hFFFE;
        #1;
        release dut.rd_cnt_q;
        m_rd = 16'hFFFE;
        check_val("rd_cnt_preload", rd_cnt, 16'hFFFE);
        core_txn(1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 3, 1'b0, 8'h00, 8'h00);
        core_txn(1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 3, 1'b0, 8'h00, 8'h00);

        // Clear together with a completing load
        cnt_clr = 1'b1;
        core_txn(1'b0, 8'h20, 8'h00, 8'h3C, 1'b0, 3, 1'b0, 8'h00, 8'h00);
        cnt_clr = 1'b0;
        tick();
        check_val("rd_cnt_after_clr", rd_cnt, 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
